// File: rtl/rsa_host_sequencer.sv
// Hardware command initiator for the accelerator: load, N x compute, read back.
module rsa_host_sequencer #(
    parameter int unsigned DATA_W      = 1024,
    parameter int unsigned CMD_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              job_start,
    output logic              job_ready,
    input  logic [DATA_W-1:0] job_operand,
    input  logic [7:0]        job_ncompute,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CMD_W-1:0]  cmd_dout,
    output logic              cmd_valid,
    input  logic              cmd_read,
    output logic [DATA_W-1:0] data_dout,
    output logic              data_dout_valid,
    input  logic [DATA_W-1:0] data_din,
    input  logic              data_din_valid,
    output logic              data_din_read,
    input  logic              done_valid,
    output logic              done_read,
    output logic [3:0]        status
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [CMD_W-1:0] CMD_LOAD = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_COMP = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_READ = CMD_W'(2);

    typedef enum logic [3:0] {
        S_IDLE      = 4'h0,
        S_LOAD_CMD  = 4'h1,
        S_LOAD_DONE = 4'h2,
        S_COMP_CMD  = 4'h3,
        S_COMP_DONE = 4'h4,
        S_RD_CMD    = 4'h5,
        S_RD_DATA   = 4'h6,
        S_RD_DONE   = 4'h7,
        S_RESULT    = 4'h8
    } state_e;

    state_e              state_q, state_d;
    logic                job_ready_q, job_ready_d;
    logic [CMD_W-1:0]    cmd_dout_q, cmd_dout_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [DATA_W-1:0]   data_dout_q, data_dout_d;
    logic                data_dout_valid_q, data_dout_valid_d;
    logic                data_din_read_q, data_din_read_d;
    logic                done_read_q, done_read_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic                res_err_q, res_err_d;
    logic                res_valid_q, res_valid_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                waiting;

    // Next-state, handshake and timeout logic
    always_comb begin
        state_d           = state_q;
        job_ready_d       = job_ready_q;
        cmd_dout_d        = cmd_dout_q;
        cmd_valid_d       = cmd_valid_q;
        data_dout_d       = data_dout_q;
        data_dout_valid_d = data_dout_valid_q;
        data_din_read_d   = 1'b0;
        done_read_d       = 1'b0;
        res_data_d        = res_data_q;
        res_err_d         = res_err_q;
        res_valid_d       = res_valid_q;
        cnt_d             = cnt_q;
        tmo_d             = tmo_q;
        waiting           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (job_start) begin
                    state_d     = S_LOAD_CMD;
                    job_ready_d = 1'b0;
                    data_dout_d = job_operand;
                    cnt_d       = job_ncompute;
                    cmd_dout_d  = CMD_LOAD;
                    cmd_valid_d = 1'b1;
                end
            end
            S_LOAD_CMD, S_COMP_CMD, S_RD_CMD: begin
                if (cmd_read) begin
                    cmd_valid_d = 1'b0;
                    if (state_q == S_LOAD_CMD) begin
                        state_d           = S_LOAD_DONE;
                        data_dout_valid_d = 1'b1;
                    end else if (state_q == S_COMP_CMD) begin
                        state_d = S_COMP_DONE;
                    end else begin
                        state_d = S_RD_DATA;
                    end
                end else begin
                    waiting = 1'b1;
                end
            end
            S_LOAD_DONE, S_COMP_DONE: begin
                if (done_valid) begin
                    done_read_d       = 1'b1;
                    data_dout_valid_d = 1'b0;
                    cmd_valid_d       = 1'b1;
                    if (state_q == S_COMP_DONE) begin
                        cnt_d = cnt_q - 8'd1;
                    end
                    if ((state_q == S_LOAD_DONE && cnt_q != 8'd0) ||
                        (state_q == S_COMP_DONE && cnt_q != 8'd1)) begin
                        state_d    = S_COMP_CMD;
                        cmd_dout_d = CMD_COMP;
                    end else begin
                        state_d    = S_RD_CMD;
                        cmd_dout_d = CMD_READ;
                    end
                end else begin
                    waiting = 1'b1;
                end
            end
            S_RD_DATA: begin
                if (data_din_valid) begin
                    res_data_d      = data_din;
                    data_din_read_d = 1'b1;
                    state_d         = S_RD_DONE;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_RD_DONE: begin
                if (done_valid) begin
                    done_read_d = 1'b1;
                    state_d     = S_RESULT;
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b0;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    job_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d           = S_IDLE;
                job_ready_d       = 1'b1;
                cmd_valid_d       = 1'b0;
                data_dout_valid_d = 1'b0;
                res_valid_d       = 1'b0;
            end
        endcase

        // Abort to an error result once a wait has lasted TIMEOUT_CYC cycles
        if (waiting) begin
            if (tmo_q == TMO_LAST) begin
                state_d           = S_RESULT;
                cmd_valid_d       = 1'b0;
                data_dout_valid_d = 1'b0;
                res_valid_d       = 1'b1;
                res_err_d         = 1'b1;
                res_data_d        = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
        if (state_d != state_q) begin
            tmo_d = '0;
        end
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= S_IDLE;
            job_ready_q       <= 1'b1;
            cmd_dout_q        <= '0;
            cmd_valid_q       <= 1'b0;
            data_dout_q       <= '0;
            data_dout_valid_q <= 1'b0;
            data_din_read_q   <= 1'b0;
            done_read_q       <= 1'b0;
            res_data_q        <= '0;
            res_err_q         <= 1'b0;
            res_valid_q       <= 1'b0;
            cnt_q             <= '0;
            tmo_q             <= '0;
        end else begin
            state_q           <= state_d;
            job_ready_q       <= job_ready_d;
            cmd_dout_q        <= cmd_dout_d;
            cmd_valid_q       <= cmd_valid_d;
            data_dout_q       <= data_dout_d;
            data_dout_valid_q <= data_dout_valid_d;
            data_din_read_q   <= data_din_read_d;
            done_read_q       <= done_read_d;
            res_data_q        <= res_data_d;
            res_err_q         <= res_err_d;
            res_valid_q       <= res_valid_d;
            cnt_q             <= cnt_d;
            tmo_q             <= tmo_d;
        end
    end

    assign job_ready       = job_ready_q;
    assign cmd_dout        = cmd_dout_q;
    assign cmd_valid       = cmd_valid_q;
    assign data_dout       = data_dout_q;
    assign data_dout_valid = data_dout_valid_q;
    assign data_din_read   = data_din_read_q;
    assign done_read       = done_read_q;
    assign res_data        = res_data_q;
    assign res_err         = res_err_q;
    assign res_valid       = res_valid_q;
    assign status          = state_q;

endmodule
